// File: rtl/ae_pkg.sv
// +----------------------------------------------------------------------------+
// | ae_pkg                                                                     |
// | Activation Q-format constants, sign-extension helper and serializer FSM    |
// | states.                                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ae_pkg;

  localparam int ACT_W    = 8;
  localparam int ACT_FRAC = 7;
  localparam int DAT_W    = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // [1,7] -> [9,7]: same binary point, so only the sign bit is replicated
  function automatic logic [DAT_W-1:0] sext_act(input logic [ACT_W-1:0] a);
    return {{(DAT_W-ACT_W){a[ACT_W-1]}}, a};
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_serializer_if.sv
// +----------------------------------------------------------------------------+
// | layer_serializer_if                                                        |
// | Parallel activation capture and serial word stream between network layers.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface layer_serializer_if #(
  parameter int NEURON_NUM = 96,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16
);

  logic [NEURON_NUM*IN_W-1:0] in_vec;
  logic                       in_valid;
  logic [OUT_W-1:0]           out_dat;
  logic                       out_valid;
  logic                       out_last;
  logic                       busy;
  logic                       ovf_err;

  modport master (
    output in_vec, in_valid,
    input  out_dat, out_valid, out_last, busy, ovf_err
  );

  modport slave (
    input  in_vec, in_valid,
    output out_dat, out_valid, out_last, busy, ovf_err
  );

endinterface

`default_nettype wire

// File: rtl/layer_serializer_vec_buf.sv
// +----------------------------------------------------------------------------+
// | vec_buf                                                                    |
// | NEURON_NUM x IN_W activation register bank with load and indexed read.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vec_buf #(
  parameter int NEURON_NUM = 96,
  parameter int IN_W       = 8,
  parameter int IDX_W      = 7
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       i_load,
  input  wire logic [NEURON_NUM*IN_W-1:0] i_vec,
  input  wire logic [IDX_W-1:0]           i_idx,
  output logic      [IN_W-1:0]            o_act
);

  logic [IN_W-1:0] r_mem [NEURON_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NEURON_NUM; k++) r_mem[k] <= '0;
    end else if (i_load) begin
      for (int k = 0; k < NEURON_NUM; k++) r_mem[k] <= i_vec[k*IN_W +: IN_W];
    end
  end

  assign o_act = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/layer_serializer.sv
// +----------------------------------------------------------------------------+
// | layer_serializer                                                           |
// | Captures a parallel activation vector and re-emits it as a gap-free,       |
// | sign-extended word burst. LAYER_SER_PINGPONG_EN adds a second buffer.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module layer_serializer
  import ae_pkg::*;
#(
  parameter int NEURON_NUM = 96,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16
) (
  input wire logic           clk,
  input wire logic           rst_n,
  layer_serializer_if.slave  io
);

  localparam int IDX_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NEURON_NUM - 1);
`ifdef LAYER_SER_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_rd_idx;
  logic             r_valid, r_last, r_ovf;
  logic             w_valid_nxt, w_last_nxt, w_ovf_nxt;
  logic [OUT_W-1:0] r_dat, w_dat_ext;
  logic [IN_W-1:0]  w_act_nxt, w_act_in0;
  logic [IN_W-1:0]  w_act_buf [NBUF];
  logic [NBUF-1:0]  w_load;
`ifdef LAYER_SER_PINGPONG_EN
  logic             r_sel, w_sel_nxt, r_pend, w_pend_nxt;
`endif

  // Read address is one ahead so the registered output shows word idx
  assign w_rd_idx  = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
  assign w_act_in0 = io.in_vec[IN_W-1:0];

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    vec_buf #(
      .NEURON_NUM (NEURON_NUM),
      .IN_W       (IN_W),
      .IDX_W      (IDX_W)
    ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[b]),
      .i_vec  (io.in_vec),
      .i_idx  (w_rd_idx),
      .o_act  (w_act_buf[b])
    );
  end

  if (IN_W == ACT_W && OUT_W == DAT_W) begin : g_sext_pkg
    assign w_dat_ext = sext_act(w_act_nxt);
  end else begin : g_sext_gen
    assign w_dat_ext = OUT_W'($signed(w_act_nxt));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_act_nxt   = w_act_in0;
    w_load      = '0;
`ifdef LAYER_SER_PINGPONG_EN
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
`endif
    unique case (r_state)
      IDLE: begin
        if (io.in_valid) begin
          w_state_nxt = STREAM;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
`ifdef LAYER_SER_PINGPONG_EN
          w_load[r_sel] = 1'b1;
`else
          w_load[0] = 1'b1;
`endif
        end
      end
      STREAM: begin
        if (r_idx != c_last_idx) begin
          w_idx_nxt   = w_rd_idx;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (w_rd_idx == c_last_idx);
`ifdef LAYER_SER_PINGPONG_EN
          w_act_nxt = w_act_buf[r_sel];
          if (io.in_valid) begin
            if (r_pend) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_load[~r_sel] = 1'b1;
              w_pend_nxt     = 1'b1;
            end
          end
`else
          w_act_nxt = w_act_buf[0];
          w_ovf_nxt = io.in_valid;
`endif
        end else begin
          w_idx_nxt = '0;
`ifdef LAYER_SER_PINGPONG_EN
          // Both buffers count as occupied until the last word has left
          if (r_pend) begin
            w_valid_nxt = 1'b1;
            w_sel_nxt   = ~r_sel;
            w_pend_nxt  = 1'b0;
            w_act_nxt   = w_act_buf[~r_sel];
            w_ovf_nxt   = io.in_valid;
          end else if (io.in_valid) begin
            w_valid_nxt   = 1'b1;
            w_load[r_sel] = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
`else
          if (io.in_valid) begin
            w_valid_nxt = 1'b1;
            w_load[0]   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dat   <= '0;
`ifdef LAYER_SER_PINGPONG_EN
      r_sel   <= 1'b0;
      r_pend  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dat   <= w_valid_nxt ? w_dat_ext : '0;
`ifdef LAYER_SER_PINGPONG_EN
      r_sel   <= w_sel_nxt;
      r_pend  <= w_pend_nxt;
`endif
    end
  end

  assign io.out_dat   = r_dat;
  assign io.out_valid = r_valid;
  assign io.out_last  = r_last;
  assign io.ovf_err   = r_ovf;
  assign io.busy      = (r_state == STREAM);

endmodule

`default_nettype wire
